// File: rtl/audio_time_counter.sv
// ============================================================================
// Module      : audio_time_counter
// Description : Elapsed-seconds counter for record/playback with speed scaling
//               and saturation at MAX_SEC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_time_counter #(
    parameter int TICKS_PER_SEC = 12000000,
    parameter int MAX_SEC       = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_stop,
    input  logic       i_fast,
    input  logic [2:0] i_speed,
    output logic [5:0] o_sec,
    output logic       o_running,
    output logic       o_done,
    output logic [1:0] o_state
);

    localparam int c_ACC_W = $clog2(TICKS_PER_SEC * 8 + 8);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_PAUSED = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [c_ACC_W-1:0] c_TPS = c_ACC_W'(TICKS_PER_SEC);
    localparam logic [5:0]         c_MAX = 6'(MAX_SEC);

    logic [1:0]         r_state;
    logic [5:0]         r_sec;
    logic [c_ACC_W-1:0] r_acc;
    logic               r_done;
    logic               r_running;

    logic [1:0]         w_state_nxt;
    logic [5:0]         w_sec_nxt;
    logic [c_ACC_W-1:0] w_acc_nxt;
    logic               w_done_nxt;

    logic [3:0]         w_speed1;
    logic [c_ACC_W-1:0] w_speed_ext;
    logic [c_ACC_W-1:0] w_inc;
    logic [c_ACC_W-1:0] w_thr;
    logic [c_ACC_W-1:0] w_sum;
    logic [5:0]         w_sec_inc;

    // Fast mode adds more per cycle; slow mode stretches the threshold instead.
    assign w_speed1    = {1'b0, i_speed} + 4'd1;
    assign w_speed_ext = c_ACC_W'(w_speed1);
    assign w_inc       = i_fast ? w_speed_ext : c_ACC_W'(1);
    assign w_thr       = i_fast ? c_TPS : c_TPS * w_speed_ext;
    assign w_sum       = r_acc + w_inc;
    assign w_sec_inc   = r_sec + 6'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_acc_nxt   = r_acc;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!i_stop && !i_pause && i_start) begin
                    w_state_nxt = c_RUN;
                    w_sec_nxt   = 6'd0;
                    w_acc_nxt   = '0;
                end
            end
            c_RUN: begin
                if (i_stop) begin
                    w_state_nxt = c_IDLE;
                    w_sec_nxt   = 6'd0;
                    w_acc_nxt   = '0;
                end else if (i_pause) begin
                    w_state_nxt = c_PAUSED;
                end else if (w_sum >= w_thr) begin
                    // Fractional remainder is dropped at each rollover.
                    w_acc_nxt = '0;
                    w_sec_nxt = w_sec_inc;
                    if (w_sec_inc == c_MAX) begin
                        w_state_nxt = c_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_acc_nxt = w_sum;
                end
            end
            c_PAUSED: begin
                if (i_stop) begin
                    w_state_nxt = c_IDLE;
                    w_sec_nxt   = 6'd0;
                    w_acc_nxt   = '0;
                end else if (!i_pause && i_start) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: begin
                if (i_stop) begin
                    w_state_nxt = c_IDLE;
                    w_sec_nxt   = 6'd0;
                    w_acc_nxt   = '0;
                end else if (i_start) begin
                    w_state_nxt = c_RUN;
                    w_sec_nxt   = 6'd0;
                    w_acc_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= c_IDLE;
            r_sec     <= 6'd0;
            r_acc     <= '0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sec     <= w_sec_nxt;
            r_acc     <= w_acc_nxt;
            r_done    <= w_done_nxt;
            r_running <= (w_state_nxt == c_RUN);
        end
    end

    assign o_sec     = r_sec;
    assign o_running = r_running;
    assign o_done    = r_done;
    assign o_state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_audio_time_counter.sv
// ============================================================================
// Module      : tb_audio_time_counter
// Description : Self-checking bench for audio_time_counter against a
//               cycle-level behavioural model of elapsed playback time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_time_counter;

    localparam int c_TPS = 10;
    localparam int c_MAX = 32;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_fast = 1'b0;
    logic [2:0] i_speed = 3'd0;
    logic [5:0] o_sec;
    logic       o_running;
    logic       o_done;
    logic [1:0] o_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: seconds and fraction of a second as plain integers.
    int         m_state = 0;
    int         m_sec = 0;
    int         m_acc = 0;
    logic       m_done = 1'b0;

    audio_time_counter #(
        .TICKS_PER_SEC(c_TPS),
        .MAX_SEC      (c_MAX)
    ) u_dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_pause  (i_pause),
        .i_stop   (i_stop),
        .i_fast   (i_fast),
        .i_speed  (i_speed),
        .o_sec    (o_sec),
        .o_running(o_running),
        .o_done   (o_done),
        .o_state  (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        m_state = 0;
        m_sec   = 0;
        m_acc   = 0;
        m_done  = 1'b0;
    endtask

    // Ticks per real second are spread over (speed+1) in slow mode and
    // compressed by (speed+1) in fast mode.
    task automatic model_step();
        int step;
        int need;
        step   = i_fast ? (int'(i_speed) + 1) : 1;
        need   = i_fast ? c_TPS : c_TPS * (int'(i_speed) + 1);
        m_done = 1'b0;
        if (m_state == 0) begin
            if (i_start && !i_pause && !i_stop) begin
                m_state = 1; m_sec = 0; m_acc = 0;
            end
        end else if (m_state == 1) begin
            if (i_stop) begin
                m_state = 0; m_sec = 0; m_acc = 0;
            end else if (i_pause) begin
                m_state = 2;
            end else if (m_acc + step >= need) begin
                m_acc = 0;
                m_sec = m_sec + 1;
                if (m_sec == c_MAX) begin
                    m_state = 3;
                    m_done  = 1'b1;
                end
            end else begin
                m_acc = m_acc + step;
            end
        end else if (m_state == 2) begin
            if (i_stop) begin
                m_state = 0; m_sec = 0; m_acc = 0;
            end else if (i_start && !i_pause) begin
                m_state = 1;
            end
        end else begin
            if (i_stop) begin
                m_state = 0; m_sec = 0; m_acc = 0;
            end else if (i_start) begin
                m_state = 1; m_sec = 0; m_acc = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic go_idle();
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        model_reset();
        #23;
        n_cmp++;
        if ({o_state, o_running, o_done, o_sec} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_outputs got state=%0d run=%0b done=%0b sec=%0d want all zero",
                     o_state, o_running, o_done, o_sec);
        end
        i_rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (o_state !== 2'd0 || o_sec !== 6'd0) begin
            n_err++;
            $display("FAIL reset_idle got state=%0d sec=%0d want state=0 sec=0", o_state, o_sec);
        end
    endtask

    task automatic test_run_1x();
        i_fast = 1'b0; i_speed = 3'd0; i_start = 1'b1;
        tick();
        for (int i = 1; i <= 35; i++) begin
            tick();
            n_cmp++;
            if ({o_state, o_running, o_done, o_sec} !== {2'(m_state), (m_state == 1), m_done, 6'(m_sec)}) begin
                n_err++;
                $display("FAIL run_1x c%0d got st=%0d run=%0b done=%0b sec=%0d want st=%0d done=%0b sec=%0d",
                         i, o_state, o_running, o_done, o_sec, m_state, m_done, m_sec);
            end
            if (i == 9 || i == 10) begin
                n_cmp++;
                if (o_sec !== 6'(i / 10)) begin
                    n_err++;
                    $display("FAIL run_1x_first_sec c%0d got sec=%0d want %0d", i, o_sec, i / 10);
                end
            end
        end
        n_cmp++;
        if (o_sec !== 6'd3 || o_running !== 1'b1) begin
            n_err++;
            $display("FAIL run_1x_final got sec=%0d run=%0b want sec=3 run=1", o_sec, o_running);
        end
        go_idle();
    endtask

    task automatic test_fast_4x();
        i_fast = 1'b1; i_speed = 3'd3; i_start = 1'b1;
        tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_cmp++;
            if ({o_state, o_done, o_sec} !== {2'(m_state), m_done, 6'(m_sec)}) begin
                n_err++;
                $display("FAIL fast_4x c%0d got st=%0d sec=%0d want st=%0d sec=%0d",
                         i, o_state, o_sec, m_state, m_sec);
            end
            if (i == 18 || i == 20) begin
                n_cmp++;
                if (o_sec !== 6'd6) begin
                    n_err++;
                    $display("FAIL fast_4x_sec c%0d got sec=%0d want 6", i, o_sec);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_slow_switch();
        i_fast = 1'b0; i_speed = 3'd1; i_start = 1'b1;
        tick();
        for (int i = 1; i <= 35; i++) begin
            tick();
            n_cmp++;
            if (o_sec !== 6'(m_sec) || o_state !== 2'(m_state)) begin
                n_err++;
                $display("FAIL slow_2x c%0d got sec=%0d want %0d", i, o_sec, m_sec);
            end
        end
        n_cmp++;
        if (o_sec !== 6'd1) begin
            n_err++;
            $display("FAIL slow_2x_sec got sec=%0d want 1", o_sec);
        end
        i_speed = 3'd0;
        tick();
        n_cmp++;
        if (o_sec !== 6'd2) begin
            n_err++;
            $display("FAIL slow_switch_rollover got sec=%0d want 2", o_sec);
        end
        tick();
        n_cmp++;
        if (o_sec !== 6'd2 || o_state !== 2'd1) begin
            n_err++;
            $display("FAIL slow_switch_after got sec=%0d st=%0d want sec=2 st=1", o_sec, o_state);
        end
        go_idle();
    endtask

    task automatic test_pause_resume();
        i_fast = 1'b0; i_speed = 3'd0; i_start = 1'b1;
        tick();
        repeat (57) tick();
        i_start = 1'b0; i_pause = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            n_cmp++;
            if (o_sec !== 6'd5 || o_state !== 2'd2 || o_running !== 1'b0) begin
                n_err++;
                $display("FAIL pause_hold c%0d got sec=%0d st=%0d run=%0b want sec=5 st=2 run=0",
                         i, o_sec, o_state, o_running);
            end
        end
        i_pause = 1'b0; i_start = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (o_sec !== 6'((i == 3) ? 6 : 5) || o_sec !== 6'(m_sec)) begin
                n_err++;
                $display("FAIL resume c%0d got sec=%0d want %0d", i, o_sec, (i == 3) ? 6 : 5);
            end
        end
        go_idle();
    endtask

    task automatic test_limit();
        i_fast = 1'b0; i_speed = 3'd0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 1; i <= 320; i++) begin
            tick();
            n_cmp++;
            if ({o_state, o_running, o_done, o_sec} !== {2'(m_state), (m_state == 1), m_done, 6'(m_sec)}) begin
                n_err++;
                $display("FAIL limit c%0d got st=%0d done=%0b sec=%0d want st=%0d done=%0b sec=%0d",
                         i, o_state, o_done, o_sec, m_state, m_done, m_sec);
            end
        end
        n_cmp++;
        if (o_sec !== 6'd32 || o_done !== 1'b1 || o_state !== 2'd3) begin
            n_err++;
            $display("FAIL limit_reach got sec=%0d done=%0b st=%0d want 32 1 3", o_sec, o_done, o_state);
        end
        repeat (5) begin
            tick();
            n_cmp++;
            if (o_sec !== 6'd32 || o_done !== 1'b0 || o_state !== 2'd3) begin
                n_err++;
                $display("FAIL limit_hold got sec=%0d done=%0b st=%0d want 32 0 3", o_sec, o_done, o_state);
            end
        end
        i_start = 1'b1;
        tick();
        n_cmp++;
        if (o_sec !== 6'd0 || o_state !== 2'd1 || o_running !== 1'b1) begin
            n_err++;
            $display("FAIL limit_restart got sec=%0d st=%0d run=%0b want 0 1 1", o_sec, o_state, o_running);
        end
        go_idle();
    endtask

    task automatic test_stop_start();
        i_fast = 1'b0; i_speed = 3'd0; i_start = 1'b1;
        tick();
        repeat (90) tick();
        n_cmp++;
        if (o_sec !== 6'd9) begin
            n_err++;
            $display("FAIL stop_start_pre got sec=%0d want 9", o_sec);
        end
        i_stop = 1'b1;
        tick();
        n_cmp++;
        if (o_sec !== 6'd0 || o_state !== 2'd0 || o_running !== 1'b0) begin
            n_err++;
            $display("FAIL stop_start got sec=%0d st=%0d run=%0b want 0 0 0", o_sec, o_state, o_running);
        end
        i_stop = 1'b0; i_pause = 1'b1;
        tick();
        n_cmp++;
        if (o_state !== 2'd0) begin
            n_err++;
            $display("FAIL start_pause_idle got st=%0d want 0", o_state);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        i_fast = 1'b0; i_speed = 3'd0; i_start = 1'b1;
        tick();
        repeat (25) tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({o_state, o_running, o_done, o_sec} !== 10'd0) begin
            n_err++;
            $display("FAIL async_reset got st=%0d run=%0b done=%0b sec=%0d want all zero",
                     o_state, o_running, o_done, o_sec);
        end
        i_start = 1'b0;
        #2;
        i_rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (o_state !== 2'd0 || o_sec !== 6'd0) begin
            n_err++;
            $display("FAIL async_reset_idle got st=%0d sec=%0d want 0 0", o_state, o_sec);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1500; i++) begin
            r       = int'($urandom_range(0, 99));
            i_stop  = (r < 2);
            i_pause = (r >= 2 && r < 6);
            i_start = (r >= 6 && r < 40);
            if ($urandom_range(0, 29) == 0) begin
                i_fast  = 1'($urandom);
                i_speed = 3'($urandom);
            end
            tick();
            n_cmp++;
            if ({o_state, o_running, o_done, o_sec} !== {2'(m_state), (m_state == 1), m_done, 6'(m_sec)}) begin
                n_err++;
                $display("FAIL random c%0d got st=%0d run=%0b done=%0b sec=%0d want st=%0d done=%0b sec=%0d",
                         i, o_state, o_running, o_done, o_sec, m_state, m_done, m_sec);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_run_1x();
        test_fast_4x();
        test_slow_switch();
        test_pause_resume();
        test_limit();
        test_stop_start();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
